ct_iu_bju_pcfifo_queue: RTL and testbench
=========================================

Name: ct_iu_bju_pcfifo_queue

Overview:
- Complete parametrised BJU PC FIFO: DEPTH entries in a circular queue, CREATE_NUM in-order allocation ports from dispatch, one BJU completion write port, and retire-side pop of up to POP_NUM oldest entries per cycle.
- Adds capabilities a standalone entry lacks: free-space backpressure, pointer management, and bulk flush-kill of cancelled entries with head rollback.
- Sits in the IU between IDU dispatch, BJU EX2 and RTU retire.

Parameters:
DEPTH, 32, number of entries; power of two, >=4
CREATE_NUM, 3, create ports per cycle; <=DEPTH/2
POP_NUM, 3, oldest entries read/popped per cycle
PC_WIDTH, 40, PC bits
CHK_WIDTH, 25, check-index bits
PTR_W, log2(DEPTH), derived pointer width

Ports:
forever_cpuclk  in  1  clock
cpurst  in  1  synchronous active-high reset
create_en  in  CREATE_NUM  thermometer create requests, port 0 first
create_data  in  CREATE_NUM*(CHK_WIDTH+2+PC_WIDTH)  {chk_idx, jmp_mispred, bht_pred, pc} per port
create_rdy  out  1  at least CREATE_NUM free entries
create_ptr  out  PTR_W  index given to create port 0; port k gets create_ptr+k
cmplt_en  in  1  BJU EX2 completion
cmplt_ptr  in  PTR_W  entry being completed
cmplt_info  in  6+PC_WIDTH  {length, bht_mispred, jmp, pret, pcall, condbr, pc}
pop_num  in  log2(POP_NUM)+1  number of head entries to pop this cycle
rt_read_data  out  POP_NUM*(11+PC_WIDTH)  head+i: {cmplt, flush, vld, length, bht_pred, bju, bht_mispred, jmp, pret, pcall, condbr, pc}
rf_ptr  in  PTR_W  random read index
rf_read_data  out  CHK_WIDTH+2+PC_WIDTH  {chk_idx, jmp_mispred, bht_pred, pc} of entry rf_ptr, combinational
iu_yy_xx_cancel  in  1  IU cancel
rtu_iu_flush_fe  in  1  front-end flush
rtu_yy_xx_flush  in  1  RTU flush
entry_cnt  out  PTR_W+1  valid entry count
empty  out  1  entry_cnt==0

Behaviour:
- Reset (sync, cpurst=1 at clock edge):
  - All vld/cmplt/flush/info bits 0; head=tail=0; entry_cnt=0.
  - create_rdy=1, create_ptr=0, empty=1, rt_read_data all 0.
  - Reset mid-operation discards all state the following cycle.
- Create:
  - Accepted only when create_rdy=1. create_rdy is registered: (DEPTH-entry_cnt_next)>=CREATE_NUM.
  - Port k writes entry tail+k (mod DEPTH): vld=1, cmplt=0, flush=0, bju/cmplt fields=0, pc=create pc.
  - tail advances by popcount(create_en); pointers wrap modulo DEPTH.
  - Non-thermometer create_en, or create while !create_rdy: ignored; assertion fires.
- Completion:
  - cmplt_en with entry vld=1: cmplt=1, bju=1, overwrite pc and the cmplt_info fields.
  - Completion to an invalid entry is ignored.
  - Same-cycle create to the same index wins over completion.
- Pop:
  - Entries head..head+pop_num-1 are cleared (vld=0, cmplt=0); head += pop_num.
  - pop_num > number of valid head entries: assertion; behaviour clamps to valid count.
- rt_read_data slot i reflects entry (head+i) mod DEPTH, registered state, zero latency. Slot vld=0 when beyond entry_cnt.
- Flush marking:
  - If iu_yy_xx_cancel or rtu_iu_flush_fe, and not rtu_yy_xx_flush: every currently valid entry gets flush=1.
  - Entries created the same cycle are not marked.
  - Marked entries are always the contiguous oldest block.
- Flush kill:
  - rtu_yy_xx_flush kills every valid entry whose flush=1.
  - If cancel or flush_fe is asserted the same cycle, it kills all valid entries instead.
  - head advances by the kill count; entry_cnt decreases by the kill count.
  - Pop is ignored in a kill cycle. Creates in the same cycle are still accepted, and their entries survive.
- entry_cnt_next = entry_cnt + creates - pops - kills. It never exceeds DEPTH; full wrap (tail==head with cnt==DEPTH) is distinguished by entry_cnt.

Decomposition:
- Shared package ct_iu_pcfifo_pkg holds:
  - Field offsets and widths for the create, rf and rt buses (RF_W=CHK_WIDTH+2+PC_WIDTH, RT_W=11+PC_WIDTH).
  - A pointer-increment-modulo function.
- Sub-module ct_iu_pcfifo_entry_p holds one parametrised entry with state and next-state logic. It is instantiated DEPTH times by generate; the top level holds the pointers, counter and read muxes.

Test Plan:
1. Reset, then create_en=3'b111 with pcs 0x100/0x104/0x108 -> create_ptr=0 before, 3 after; entry_cnt=3; rt_read_data slots 0..2 vld=1, cmplt=0, pc matching.
2. cmplt_en ptr=1, pc=0x2000, jmp=1 -> slot1 cmplt=1, bju=1, jmp=1, pc=0x2000; slots 0 and 2 unchanged.
3. Fill to DEPTH-2 entries -> create_rdy=0; a create attempt is ignored (entry_cnt stays 30, assertion fires); pop_num=3 -> create_rdy=1 next cycle.
4. 5 valid entries; iu_yy_xx_cancel plus 2 creates -> old 5 flagged, new 2 not; next cycle rtu_yy_xx_flush -> entry_cnt=2, head advanced by 5.
5. Wrap-around: run 3*DEPTH creates and pops interleaved -> data order preserved at head; entry_cnt never exceeds DEPTH.
6. cpurst asserted with 10 valid entries -> next cycle entry_cnt=0, empty=1, all rt slots vld=0.

Source files
------------

// File: rtl/ct_iu_pcfifo_pkg.sv
// Shared field layout and pointer helper for the BJU PC FIFO.
// Field offsets are bit positions above the pc field of each bus.
package ct_iu_pcfifo_pkg;

    localparam int CR_BHT_PRED    = 0;
    localparam int CR_JMP_MISPRED = 1;
    localparam int CR_CHK         = 2;
    localparam int CR_EXT         = 2;

    localparam int CI_CONDBR      = 0;
    localparam int CI_PCALL       = 1;
    localparam int CI_PRET        = 2;
    localparam int CI_JMP         = 3;
    localparam int CI_BHT_MISPRED = 4;
    localparam int CI_LENGTH      = 5;
    localparam int CI_EXT         = 6;

    localparam int RT_CONDBR      = 0;
    localparam int RT_PCALL       = 1;
    localparam int RT_PRET        = 2;
    localparam int RT_JMP         = 3;
    localparam int RT_BHT_MISPRED = 4;
    localparam int RT_BJU         = 5;
    localparam int RT_BHT_PRED    = 6;
    localparam int RT_LENGTH      = 7;
    localparam int RT_VLD         = 8;
    localparam int RT_FLUSH       = 9;
    localparam int RT_CMPLT       = 10;
    localparam int RT_EXT         = 11;

    function automatic int rf_width(input int pc_w, input int chk_w);
        return chk_w + CR_EXT + pc_w;
    endfunction

    function automatic int rt_width(input int pc_w);
        return RT_EXT + pc_w;
    endfunction

    // depth is a power of two, so the modulo is a mask
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] inc,
                                            input logic [31:0] depth);
        return (ptr + inc) & (depth - 32'd1);
    endfunction

endpackage

// File: rtl/ct_iu_pcfifo_entry_p.sv
// One PC FIFO entry: create/complete/clear/flush-mark state and its read views.
module ct_iu_pcfifo_entry_p
    import ct_iu_pcfifo_pkg::*;
#(
    parameter int PC_WIDTH  = 40,
    parameter int CHK_WIDTH = 25,
    localparam int RF_W = rf_width(PC_WIDTH, CHK_WIDTH),
    localparam int RT_W = rt_width(PC_WIDTH),
    localparam int CI_W = CI_EXT + PC_WIDTH
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst,
    input  logic            create_en,
    input  logic [RF_W-1:0] create_data,
    input  logic            cmplt_en,
    input  logic [CI_W-1:0] cmplt_info,
    input  logic            clr_en,
    input  logic            flush_mark,
    output logic            vld,
    output logic            flush,
    output logic [RF_W-1:0] rf_data,
    output logic [RT_W-1:0] rt_data
);

    logic                 cmplt;
    logic                 bju;
    logic                 bht_pred;
    logic                 jmp_mispred;
    logic [CHK_WIDTH-1:0] chk_idx;
    logic                 length;
    logic                 bht_mispred;
    logic                 jmp;
    logic                 pret;
    logic                 pcall;
    logic                 condbr;
    logic [PC_WIDTH-1:0]  pc;

    // create beats clear, clear beats completion and flush marking
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            vld         <= 1'b0;
            cmplt       <= 1'b0;
            flush       <= 1'b0;
            bju         <= 1'b0;
            bht_pred    <= 1'b0;
            jmp_mispred <= 1'b0;
            chk_idx     <= '0;
            length      <= 1'b0;
            bht_mispred <= 1'b0;
            jmp         <= 1'b0;
            pret        <= 1'b0;
            pcall       <= 1'b0;
            condbr      <= 1'b0;
            pc          <= '0;
        end else if (create_en) begin
            vld         <= 1'b1;
            cmplt       <= 1'b0;
            flush       <= 1'b0;
            bju         <= 1'b0;
            bht_pred    <= create_data[PC_WIDTH+CR_BHT_PRED];
            jmp_mispred <= create_data[PC_WIDTH+CR_JMP_MISPRED];
            chk_idx     <= create_data[PC_WIDTH+CR_CHK +: CHK_WIDTH];
            length      <= 1'b0;
            bht_mispred <= 1'b0;
            jmp         <= 1'b0;
            pret        <= 1'b0;
            pcall       <= 1'b0;
            condbr      <= 1'b0;
            pc          <= create_data[PC_WIDTH-1:0];
        end else if (clr_en) begin
            vld   <= 1'b0;
            cmplt <= 1'b0;
            flush <= 1'b0;
        end else begin
            if (cmplt_en && vld) begin
                cmplt       <= 1'b1;
                bju         <= 1'b1;
                length      <= cmplt_info[PC_WIDTH+CI_LENGTH];
                bht_mispred <= cmplt_info[PC_WIDTH+CI_BHT_MISPRED];
                jmp         <= cmplt_info[PC_WIDTH+CI_JMP];
                pret        <= cmplt_info[PC_WIDTH+CI_PRET];
                pcall       <= cmplt_info[PC_WIDTH+CI_PCALL];
                condbr      <= cmplt_info[PC_WIDTH+CI_CONDBR];
                pc          <= cmplt_info[PC_WIDTH-1:0];
            end
            if (flush_mark && vld) begin
                flush <= 1'b1;
            end
        end
    end

    assign rf_data = {chk_idx, jmp_mispred, bht_pred, pc};
    assign rt_data = {cmplt, flush, vld, length, bht_pred, bju, bht_mispred,
                      jmp, pret, pcall, condbr, pc};

endmodule

// File: rtl/ct_iu_bju_pcfifo_queue.sv
// BJU PC FIFO: circular queue of entries with in-order create, random completion,
// retire pop of the oldest entries and flush-kill of the cancelled oldest block.
module ct_iu_bju_pcfifo_queue
    import ct_iu_pcfifo_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int CREATE_NUM = 3,
    parameter int POP_NUM    = 3,
    parameter int PC_WIDTH   = 40,
    parameter int CHK_WIDTH  = 25,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int RF_W   = rf_width(PC_WIDTH, CHK_WIDTH),
    localparam int RT_W   = rt_width(PC_WIDTH),
    localparam int CI_W   = CI_EXT + PC_WIDTH,
    localparam int POPN_W = $clog2(POP_NUM) + 1
) (
    input  logic                       forever_cpuclk,
    input  logic                       cpurst,
    input  logic [CREATE_NUM-1:0]      create_en,
    input  logic [CREATE_NUM*RF_W-1:0] create_data,
    output logic                       create_rdy,
    output logic [PTR_W-1:0]           create_ptr,
    input  logic                       cmplt_en,
    input  logic [PTR_W-1:0]           cmplt_ptr,
    input  logic [CI_W-1:0]            cmplt_info,
    input  logic [POPN_W-1:0]          pop_num,
    output logic [POP_NUM*RT_W-1:0]    rt_read_data,
    input  logic [PTR_W-1:0]           rf_ptr,
    output logic [RF_W-1:0]            rf_read_data,
    input  logic                       iu_yy_xx_cancel,
    input  logic                       rtu_iu_flush_fe,
    input  logic                       rtu_yy_xx_flush,
    output logic [PTR_W:0]             entry_cnt,
    output logic                       empty
);

    logic [PTR_W-1:0]            head;
    logic [PTR_W-1:0]            tail;
    logic [DEPTH-1:0]            e_vld;
    logic [DEPTH-1:0]            e_flush;
    logic [DEPTH-1:0][RF_W-1:0]  e_rf;
    logic [DEPTH-1:0][RT_W-1:0]  e_rt;
    logic [DEPTH-1:0]            kill_mask;
    logic [CREATE_NUM-1:0]       create_en_p1;
    logic                        create_thermo;
    logic                        create_ok;
    logic                        flush_req;
    logic                        flush_mark;
    int                          create_cnt_i;
    int                          kill_i;
    int                          head_avail_i;
    int                          pop_i;
    int                          cnt_nxt_i;
    logic [PTR_W-1:0]            head_nxt;
    logic [PTR_W-1:0]            tail_nxt;
    logic [PTR_W:0]              cnt_nxt;
    logic                        rdy_nxt;

    // thermometer from port 0 means adding one clears every set bit
    assign create_en_p1  = create_en + CREATE_NUM'(1);
    assign create_thermo = (create_en_p1 & create_en) == '0;
    assign create_ok     = create_rdy && create_thermo;
    assign flush_req     = iu_yy_xx_cancel || rtu_iu_flush_fe;
    assign flush_mark    = flush_req && !rtu_yy_xx_flush;

    always_comb begin
        create_cnt_i = 0;
        if (create_ok) begin
            for (int k = 0; k < CREATE_NUM; k++) begin
                create_cnt_i = create_cnt_i + (create_en[k] ? 1 : 0);
            end
        end
        kill_mask = '0;
        if (rtu_yy_xx_flush) begin
            kill_mask = flush_req ? e_vld : (e_vld & e_flush);
        end
        kill_i = 0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_i = kill_i + (kill_mask[i] ? 1 : 0);
        end
        head_avail_i = (int'(entry_cnt) < POP_NUM) ? int'(entry_cnt) : POP_NUM;
        pop_i = 0;
        if (!rtu_yy_xx_flush) begin
            pop_i = (int'(pop_num) > head_avail_i) ? head_avail_i : int'(pop_num);
        end
        cnt_nxt_i = int'(entry_cnt) + create_cnt_i - pop_i - kill_i;
        cnt_nxt   = (PTR_W+1)'(cnt_nxt_i);
        rdy_nxt   = (DEPTH - cnt_nxt_i) >= CREATE_NUM;
        head_nxt  = PTR_W'(ptr_inc(32'(head), 32'(pop_i + kill_i), 32'(DEPTH)));
        tail_nxt  = PTR_W'(ptr_inc(32'(tail), 32'(create_cnt_i), 32'(DEPTH)));
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            head       <= '0;
            tail       <= '0;
            entry_cnt  <= '0;
            create_rdy <= 1'b1;
        end else begin
            head       <= head_nxt;
            tail       <= tail_nxt;
            entry_cnt  <= cnt_nxt;
            create_rdy <= rdy_nxt;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst) begin
            assert (create_thermo)
                else $error("pcfifo: non-thermometer create_en %b", create_en);
            assert (create_en == '0 || create_rdy)
                else $error("pcfifo: create while create_rdy is low");
            assert (rtu_yy_xx_flush || int'(pop_num) <= head_avail_i)
                else $error("pcfifo: pop_num %0d beyond valid head entries", pop_num);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PTR_W-1:0] off_h;
        logic [PTR_W-1:0] off_t;
        logic             ent_create;
        logic             ent_clr;
        logic             ent_cmplt;
        logic [RF_W-1:0]  ent_cdata;

        // distance from head/tail decides which pop slot or create port owns this entry
        assign off_h      = PTR_W'(i) - head;
        assign off_t      = PTR_W'(i) - tail;
        assign ent_create = int'(off_t) < create_cnt_i;
        assign ent_clr    = kill_mask[i] || (int'(off_h) < pop_i);
        assign ent_cmplt  = cmplt_en && (cmplt_ptr == PTR_W'(i));

        always_comb begin
            ent_cdata = '0;
            for (int k = 0; k < CREATE_NUM; k++) begin
                if (off_t == PTR_W'(k)) begin
                    ent_cdata = create_data[k*RF_W +: RF_W];
                end
            end
        end

        ct_iu_pcfifo_entry_p #(
            .PC_WIDTH  (PC_WIDTH),
            .CHK_WIDTH (CHK_WIDTH)
        ) u_entry (
            .forever_cpuclk (forever_cpuclk),
            .cpurst         (cpurst),
            .create_en      (ent_create),
            .create_data    (ent_cdata),
            .cmplt_en       (ent_cmplt),
            .cmplt_info     (cmplt_info),
            .clr_en         (ent_clr),
            .flush_mark     (flush_mark),
            .vld            (e_vld[i]),
            .flush          (e_flush[i]),
            .rf_data        (e_rf[i]),
            .rt_data        (e_rt[i])
        );
    end

    for (genvar s = 0; s < POP_NUM; s++) begin : g_rt
        logic [PTR_W-1:0] rd_idx;
        logic [RT_W-1:0]  rd_slot;

        assign rd_idx = PTR_W'(ptr_inc(32'(head), 32'(s), 32'(DEPTH)));

        always_comb begin
            rd_slot = e_rt[rd_idx];
            if (int'(entry_cnt) <= s) begin
                rd_slot[PC_WIDTH+RT_VLD] = 1'b0;
            end
        end

        assign rt_read_data[s*RT_W +: RT_W] = rd_slot;
    end

    assign rf_read_data = e_rf[rf_ptr];
    assign create_ptr   = tail;
    assign empty        = (entry_cnt == '0);

endmodule

// File: tb/tb_ct_iu_bju_pcfifo_queue.sv
// Directed bench for the BJU PC FIFO with a queue model of the in-flight pcs.
module tb_ct_iu_bju_pcfifo_queue;

    localparam int DEPTH = 32;
    localparam int CN    = 3;
    localparam int PN    = 3;
    localparam int PCW   = 40;
    localparam int CW    = 25;
    localparam int RF_W  = CW + 2 + PCW;
    localparam int RT_W  = 11 + PCW;
    localparam int CI_W  = 6 + PCW;
    localparam int B_CONDBR = PCW + 0;
    localparam int B_JMP    = PCW + 3;
    localparam int B_BJU    = PCW + 5;
    localparam int B_BPRED  = PCW + 6;
    localparam int B_VLD    = PCW + 8;
    localparam int B_FLUSH  = PCW + 9;
    localparam int B_CMPLT  = PCW + 10;

    logic                   clk = 1'b0;
    logic                   cpurst;
    logic [CN-1:0]          create_en;
    logic [CN*RF_W-1:0]     create_data;
    logic                   create_rdy;
    logic [4:0]             create_ptr;
    logic                   cmplt_en;
    logic [4:0]             cmplt_ptr;
    logic [CI_W-1:0]        cmplt_info;
    logic [2:0]             pop_num;
    logic [PN*RT_W-1:0]     rt_read_data;
    logic [4:0]             rf_ptr;
    logic [RF_W-1:0]        rf_read_data;
    logic                   cancel;
    logic                   flush_fe;
    logic                   rtu_flush;
    logic [5:0]             entry_cnt;
    logic                   empty;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [39:0] q[$];
    logic [39:0] pc_seq = 40'h1000;
    int          mtail = 0;

    always #5 clk = ~clk;

    ct_iu_bju_pcfifo_queue dut (
        .forever_cpuclk  (clk),
        .cpurst          (cpurst),
        .create_en       (create_en),
        .create_data     (create_data),
        .create_rdy      (create_rdy),
        .create_ptr      (create_ptr),
        .cmplt_en        (cmplt_en),
        .cmplt_ptr       (cmplt_ptr),
        .cmplt_info      (cmplt_info),
        .pop_num         (pop_num),
        .rt_read_data    (rt_read_data),
        .rf_ptr          (rf_ptr),
        .rf_read_data    (rf_read_data),
        .iu_yy_xx_cancel (cancel),
        .rtu_iu_flush_fe (flush_fe),
        .rtu_yy_xx_flush (rtu_flush),
        .entry_cnt       (entry_cnt),
        .empty           (empty)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RT_W-1:0] slot(input int i);
        return rt_read_data[i*RT_W +: RT_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        create_en = '0;
        cmplt_en  = 1'b0;
        pop_num   = '0;
        cancel    = 1'b0;
        flush_fe  = 1'b0;
        rtu_flush = 1'b0;
    endtask

    task automatic drive_create(input int nc);
        create_en = CN'((1 << nc) - 1);
        for (int k = 0; k < nc; k++) begin
            create_data[k*RF_W +: RF_W] = {CW'(k + 1), 1'b0, 1'b0, pc_seq + 40'(4 * k)};
        end
    endtask

    task automatic commit_create(input int nc);
        for (int k = 0; k < nc; k++) q.push_back(pc_seq + 40'(4 * k));
        pc_seq = pc_seq + 40'(4 * nc);
        mtail  = (mtail + nc) % DEPTH;
    endtask

    // one cycle of creates (only when the model says there is room) and head pops
    task automatic cycle(input int nc_req, input int np);
        logic [RT_W-1:0] s;
        bit mrdy;
        int nc;
        mrdy = (DEPTH - q.size()) >= CN;
        chk("create_rdy", 64'(create_rdy), 64'(mrdy));
        for (int i = 0; i < np; i++) begin
            s = slot(i);
            chk($sformatf("pop_pc[%0d]", i), 64'(s[PCW-1:0]), 64'(q[i]));
            chk($sformatf("pop_vld[%0d]", i), 64'(s[B_VLD]), 64'd1);
        end
        nc = mrdy ? nc_req : 0;
        drive_create(nc);
        pop_num = 3'(np);
        tick();
        idle();
        commit_create(nc);
        for (int i = 0; i < np; i++) void'(q.pop_front());
        chk("entry_cnt", 64'(entry_cnt), 64'(q.size()));
        chk("create_ptr", 64'(create_ptr), 64'(mtail));
    endtask

    initial begin
        logic [RT_W-1:0] s;
        int created;
        int guard;
        int np;
        idle();
        cpurst      = 1'b1;
        create_data = '0;
        cmplt_ptr   = '0;
        cmplt_info  = '0;
        rf_ptr      = '0;
        tick();
        tick();
        cpurst = 1'b0;

        chk("rst_create_rdy", 64'(create_rdy), 64'd1);
        chk("rst_create_ptr", 64'(create_ptr), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_entry_cnt", 64'(entry_cnt), 64'd0);
        chk("rst_rt_zero", 64'(rt_read_data == '0), 64'd1);

        // three creates in one cycle
        create_en = 3'b111;
        for (int k = 0; k < 3; k++) begin
            create_data[k*RF_W +: RF_W] = {CW'(k + 1), 1'b0, 1'(k == 0), 40'h100 + 40'(4 * k)};
        end
        tick();
        idle();
        q.push_back(40'h100); q.push_back(40'h104); q.push_back(40'h108);
        mtail = 3;
        chk("t1_create_ptr", 64'(create_ptr), 64'd3);
        chk("t1_entry_cnt", 64'(entry_cnt), 64'd3);
        chk("t1_empty", 64'(empty), 64'd0);
        for (int i = 0; i < 3; i++) begin
            s = slot(i);
            chk($sformatf("t1_vld[%0d]", i), 64'(s[B_VLD]), 64'd1);
            chk($sformatf("t1_cmplt[%0d]", i), 64'(s[B_CMPLT]), 64'd0);
            chk($sformatf("t1_pc[%0d]", i), 64'(s[PCW-1:0]), 64'(q[i]));
        end
        s = slot(0);
        chk("t1_bht_pred0", 64'(s[B_BPRED]), 64'd1);
        rf_ptr = 5'd2;
        #1;
        chk("t1_rf2", 64'(rf_read_data), 64'({CW'(3), 1'b0, 1'b0, 40'h108}));

        // completion of entry 1 with jmp set
        cmplt_en   = 1'b1;
        cmplt_ptr  = 5'd1;
        cmplt_info = {6'b000_1_0_0 << 0, 40'h2000};
        cmplt_info[B_JMP] = 1'b1;
        cmplt_info[B_CONDBR] = 1'b0;
        tick();
        idle();
        q[1] = 40'h2000;
        s = slot(1);
        chk("t2_cmplt1", 64'(s[B_CMPLT]), 64'd1);
        chk("t2_bju1", 64'(s[B_BJU]), 64'd1);
        chk("t2_jmp1", 64'(s[B_JMP]), 64'd1);
        chk("t2_pc1", 64'(s[PCW-1:0]), 64'h2000);
        s = slot(0);
        chk("t2_cmplt0", 64'(s[B_CMPLT]), 64'd0);
        chk("t2_pc0", 64'(s[PCW-1:0]), 64'h100);
        s = slot(2);
        chk("t2_bju2", 64'(s[B_BJU]), 64'd0);
        chk("t2_pc2", 64'(s[PCW-1:0]), 64'h108);

        // completion aimed at the free entry 3 must leave no trace
        cmplt_en   = 1'b1;
        cmplt_ptr  = 5'd3;
        cmplt_info = {6'b111111, 40'hdead};
        tick();
        idle();
        chk("t2_inv_cnt", 64'(entry_cnt), 64'd3);
        cycle(1, 0);
        cycle(0, 3);
        s = slot(0);
        chk("t2_inv_cmplt", 64'(s[B_CMPLT]), 64'd0);
        chk("t2_inv_bju", 64'(s[B_BJU]), 64'd0);
        chk("t2_inv_pc", 64'(s[PCW-1:0]), 64'(q[0]));
        cycle(0, 1);

        // fill to DEPTH-2 and try to overfill
        repeat (10) cycle(3, 0);
        chk("t3_rdy_low", 64'(create_rdy), 64'd0);
        chk("t3_cnt30", 64'(entry_cnt), 64'd30);
        $assertoff;
        drive_create(3);
        tick();
        idle();
        $asserton;
        chk("t3_ignored_cnt", 64'(entry_cnt), 64'd30);
        chk("t3_ignored_ptr", 64'(create_ptr), 64'(mtail));
        cycle(0, 3);
        chk("t3_rdy_back", 64'(create_rdy), 64'd1);
        while (q.size() > 0) cycle(0, (q.size() < 3) ? q.size() : 3);

        // cancel marks the 5 old entries, the 2 created alongside survive the kill
        cycle(3, 0);
        cycle(2, 0);
        cancel = 1'b1;
        drive_create(2);
        tick();
        idle();
        commit_create(2);
        chk("t4_cnt7", 64'(entry_cnt), 64'd7);
        for (int i = 0; i < 3; i++) begin
            s = slot(i);
            chk($sformatf("t4_flag[%0d]", i), 64'(s[B_FLUSH]), 64'd1);
        end
        rtu_flush = 1'b1;
        tick();
        idle();
        repeat (5) void'(q.pop_front());
        chk("t4_cnt2", 64'(entry_cnt), 64'd2);
        for (int i = 0; i < 2; i++) begin
            s = slot(i);
            chk($sformatf("t4_new_pc[%0d]", i), 64'(s[PCW-1:0]), 64'(q[i]));
            chk($sformatf("t4_new_vld[%0d]", i), 64'(s[B_VLD]), 64'd1);
            chk($sformatf("t4_new_flag[%0d]", i), 64'(s[B_FLUSH]), 64'd0);
        end
        s = slot(2);
        chk("t4_slot2_vld", 64'(s[B_VLD]), 64'd0);
        cycle(0, 2);

        // cancel and RTU flush together kill every old entry, new create survives
        cycle(3, 0);
        cancel    = 1'b1;
        rtu_flush = 1'b1;
        drive_create(1);
        tick();
        idle();
        q.delete();
        commit_create(1);
        chk("t4b_cnt1", 64'(entry_cnt), 64'd1);
        s = slot(0);
        chk("t4b_pc", 64'(s[PCW-1:0]), 64'(q[0]));
        cycle(0, 1);

        // long interleaved traffic wrapping the pointers several times
        created = 0;
        guard   = 0;
        while (created < 3 * DEPTH && guard < 400) begin
            np = $urandom_range(0, 3);
            if (np > q.size()) np = q.size();
            if ((DEPTH - q.size()) >= CN) created += 3;
            cycle(3, np);
            chk("t5_cnt_le_depth", 64'(entry_cnt <= 6'd32), 64'd1);
            guard++;
        end
        chk("t5_done", 64'(created >= 3 * DEPTH), 64'd1);
        while (q.size() > 0) cycle(0, (q.size() < 3) ? q.size() : 3);

        // reset with 10 live entries
        cycle(3, 0); cycle(3, 0); cycle(3, 0); cycle(1, 0);
        chk("t6_cnt10", 64'(entry_cnt), 64'd10);
        cpurst = 1'b1;
        tick();
        cpurst = 1'b0;
        q.delete();
        mtail = 0;
        chk("t6_cnt0", 64'(entry_cnt), 64'd0);
        chk("t6_empty", 64'(empty), 64'd1);
        chk("t6_rdy", 64'(create_rdy), 64'd1);
        chk("t6_ptr", 64'(create_ptr), 64'd0);
        for (int i = 0; i < 3; i++) begin
            s = slot(i);
            chk($sformatf("t6_vld[%0d]", i), 64'(s[B_VLD]), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
